// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared DRAM command/op encodings, address field map and default timings
package dram_pkg;

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4
   } cmd_e;

   typedef enum logic [1:0] {
      OP_RD = 2'd0,
      OP_WR = 2'd1,
      OP_IF = 2'd2
   } op_e;

   // Physical address field positions (34-bit byte address).
   localparam int ROW_LSB  = 18;
   localparam int ROW_W    = 16;
   localparam int COLH_LSB = 12;
   localparam int COLH_W   = 6;
   localparam int COLL_LSB = 2;
   localparam int COLL_W   = 4;
   localparam int BA_LSB   = 10;
   localparam int BA_W     = 2;
   localparam int BG_LSB   = 7;
   localparam int BG_W     = 3;
   localparam int COL_W    = COLH_W + COLL_W;

   // Default DRAM timings in DRAM clock cycles.
   localparam int DEF_T_RCD   = 39;
   localparam int DEF_T_RAS   = 76;
   localparam int DEF_T_RTP   = 18;
   localparam int DEF_T_CWL   = 38;
   localparam int DEF_T_BURST = 8;
   localparam int DEF_T_WR    = 30;
   localparam int DEF_T_RP    = 39;

   // Down-counter width; must hold the largest reload value.
   localparam int CNT_W = 8;

endpackage

// File: rtl/dram_addr_decode.sv
// rtl/dram_addr_decode.sv - combinational physical address to row/col/bank-group/bank split
module dram_addr_decode
   import dram_pkg::*;
(
   input  logic [33:0]      addr,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic [BG_W-1:0]  bg,
   output logic [BA_W-1:0]  ba
);

   // Channel bit and byte-within-word bits do not select anything here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[6], addr[1:0]};

   assign row = addr[ROW_LSB +: ROW_W];
   assign col = {addr[COLH_LSB +: COLH_W], addr[COLL_LSB +: COLL_W]};
   assign ba  = addr[BA_LSB +: BA_W];
   assign bg  = addr[BG_LSB +: BG_W];

endmodule

// File: rtl/dram_cmd_issuer.sv
// rtl/dram_cmd_issuer.sv - closed-page ACT -> RD/WR -> PRE issuer with timestamped command strobes
module dram_cmd_issuer
   import dram_pkg::*;
#(
   parameter int ADDR_W  = 34,
   parameter int TIME_W  = 32,
   parameter int T_RCD   = DEF_T_RCD,
   parameter int T_RAS   = DEF_T_RAS,
   parameter int T_RTP   = DEF_T_RTP,
   parameter int T_CWL   = DEF_T_CWL,
   parameter int T_BURST = DEF_T_BURST,
   parameter int T_WR    = DEF_T_WR,
   parameter int T_RP    = DEF_T_RP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              cmd_valid,
   output logic [2:0]        cmd_code,
   output logic [2:0]        cmd_bg,
   output logic [1:0]        cmd_ba,
   output logic [15:0]       cmd_row,
   output logic [9:0]        cmd_col,
   output logic [TIME_W-1:0] cmd_time,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_PRE, S_PRE, S_WAIT_RP
   } state_e;

   // Reload values: a counter loaded on leaving state X reads 0 in the
   // cycle before the next command is due, so each load is "gap - 2".
   localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 2);
   localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(T_RAS - 2);
   localparam logic [CNT_W-1:0] LD_RTP = CNT_W'(T_RTP - 2);
   localparam logic [CNT_W-1:0] LD_WRP = CNT_W'(T_CWL + T_BURST + T_WR - 2);
   localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 2);

   state_e             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [CNT_W-1:0]   ras, ras_nxt;
   logic [TIME_W-1:0]  ts;
   logic               accept;
   logic               is_wr;

   logic [15:0]        dec_row, lat_row;
   logic [9:0]         dec_col, lat_col;
   logic [2:0]         dec_bg, lat_bg;
   logic [1:0]         dec_ba, lat_ba;

   dram_addr_decode u_decode (
      .addr (req_addr),
      .row  (dec_row),
      .col  (dec_col),
      .bg   (dec_bg),
      .ba   (dec_ba)
   );

   assign req_ready = (state == S_IDLE);
   assign busy      = ~req_ready;
   assign accept    = req_valid && req_ready;

   // State register and the two timing down-counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         ras   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ras   <= ras_nxt;
      end
   end

   // Next-state logic; counters saturate at zero unless reloaded.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
      ras_nxt   = (ras != '0) ? ras - 1'b1 : ras;
      case (state)
         S_IDLE:     if (accept) state_nxt = S_ACT;
         S_ACT: begin
            state_nxt = S_WAIT_RCD;
            cnt_nxt   = LD_RCD;
            ras_nxt   = LD_RAS;
         end
         S_WAIT_RCD: if (cnt == '0) state_nxt = S_RW;
         S_RW: begin
            state_nxt = S_WAIT_PRE;
            cnt_nxt   = is_wr ? LD_WRP : LD_RTP;
         end
         S_WAIT_PRE: if ((cnt == '0) && (ras == '0)) state_nxt = S_PRE;
         S_PRE: begin
            state_nxt = S_WAIT_RP;
            cnt_nxt   = LD_RP;
         end
         S_WAIT_RP:  if (cnt == '0) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Capture decoded fields and direction at accept; held until the PRE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_row <= '0;
         lat_col <= '0;
         lat_bg  <= '0;
         lat_ba  <= '0;
         is_wr   <= 1'b0;
      end else if (accept) begin
         lat_row <= dec_row;
         lat_col <= dec_col;
         lat_bg  <= dec_bg;
         lat_ba  <= dec_ba;
         is_wr   <= (req_op == OP_WR);
      end
   end

   // Timestamp and registered command strobe, driven one cycle ahead from state_nxt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts        <= '0;
         cmd_valid <= 1'b0;
         cmd_code  <= CMD_NOP;
         cmd_row   <= '0;
         cmd_col   <= '0;
         cmd_bg    <= '0;
         cmd_ba    <= '0;
         cmd_time  <= '0;
      end else begin
         ts        <= ts + 1'b1;
         cmd_valid <= 1'b0;
         cmd_code  <= CMD_NOP;
         case (state_nxt)
            S_ACT: begin
               cmd_valid <= 1'b1;
               cmd_code  <= CMD_ACT;
               cmd_row   <= dec_row;
               cmd_col   <= dec_col;
               cmd_bg    <= dec_bg;
               cmd_ba    <= dec_ba;
               cmd_time  <= ts + 1'b1;
            end
            S_RW, S_PRE: begin
               cmd_valid <= 1'b1;
               cmd_code  <= (state_nxt == S_PRE) ? CMD_PRE : (is_wr ? CMD_WR : CMD_RD);
               cmd_row   <= lat_row;
               cmd_col   <= lat_col;
               cmd_bg    <= lat_bg;
               cmd_ba    <= lat_ba;
               cmd_time  <= ts + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// tb/tb_dram_cmd_issuer.sv - scoreboard bench for dram_cmd_issuer
module tb_dram_cmd_issuer;
   import dram_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [1:0]  req_op = 2'd0;
   logic [33:0] req_addr = '0;
   logic        req_ready, cmd_valid, busy;
   logic [2:0]  cmd_code, cmd_bg;
   logic [1:0]  cmd_ba;
   logic [15:0] cmd_row;
   logic [9:0]  cmd_col;
   logic [31:0] cmd_time;

   dram_cmd_issuer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .cmd_valid (cmd_valid),
      .cmd_code  (cmd_code),
      .cmd_bg    (cmd_bg),
      .cmd_ba    (cmd_ba),
      .cmd_row   (cmd_row),
      .cmd_col   (cmd_col),
      .cmd_time  (cmd_time),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  code;
      logic [31:0] t;
      logic [15:0] row;
      logic [9:0]  col;
      logic [2:0]  bg;
      logic [1:0]  ba;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   int   cyc;
   int   acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push3(input logic [2:0] rw, input logic [15:0] row, input logic [9:0] col,
                        input logic [2:0] bg, input logic [1:0] ba,
                        input int t_act, input int t_rw, input int t_pre);
      sb.push_back('{CMD_ACT, t_act, row, col, bg, ba});
      sb.push_back('{rw, t_rw, row, col, bg, ba});
      sb.push_back('{CMD_PRE, t_pre, row, col, bg, ba});
   endtask

   // Bench cycle number equals the DUT timestamp while out of reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Illegal op code is flagged but still expected to run as a read.
   always @(posedge clk) begin
      if (rst_n && req_valid && req_ready && req_op == 2'd3)
         $display("note: req_op=3 offered at cycle %0d, expected to run as read", cyc);
   end

   // Monitor: pop and compare on every command strobe.
   always @(negedge clk) begin
      if (rst_n && cmd_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got code=%0d time=%0d want none", cmd_code, cmd_time);
         end else begin
            e = sb.pop_front();
            check("cmd_code", cmd_code, e.code);
            check("cmd_time", cmd_time, e.t);
            if (e.code == CMD_ACT) check("cmd_row", cmd_row, e.row);
            if (e.code == CMD_RD || e.code == CMD_WR) check("cmd_col", cmd_col, e.col);
            check("cmd_bg", cmd_bg, e.bg);
            check("cmd_ba", cmd_ba, e.ba);
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_valid", cmd_valid, 0);
      check("rst_code", cmd_code, CMD_NOP);
      check("rst_time", cmd_time, 0);
      rst_n = 1'b1;
   endtask

   task automatic offer(input logic [1:0] op, input logic [33:0] addr);
      wait_until(10);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
   endtask

   initial begin
      // Single read accepted at cycle 10.
      do_reset();
      offer(2'd0, 34'h0_0004_0C80);
      push3(CMD_RD, 16'h0001, 10'h000, 3'd1, 2'd3, 11, 50, 87);
      @(negedge clk);
      req_valid = 1'b0;
      check("rd_ready_drop", req_ready, 0);
      check("rd_busy", busy, 1);
      wait_until(125);
      check("rd_ready_125", req_ready, 0);
      wait_until(126);
      check("rd_ready_126", req_ready, 1);
      check("rd_sb_empty", sb.size(), 0);

      // Single write: write recovery sets the PRE time.
      do_reset();
      offer(2'd1, 34'h0_0004_0C80);
      push3(CMD_WR, 16'h0001, 10'h000, 3'd1, 2'd3, 11, 50, 126);
      @(negedge clk);
      req_valid = 1'b0;
      wait_until(164);
      check("wr_ready_164", req_ready, 0);
      wait_until(165);
      check("wr_ready_165", req_ready, 1);
      check("wr_sb_empty", sb.size(), 0);

      // Back-to-back: read then ifetch at the all-ones address, valid held.
      do_reset();
      offer(2'd0, 34'h0_0004_0C80);
      push3(CMD_RD, 16'h0001, 10'h000, 3'd1, 2'd3, 11, 50, 87);
      push3(CMD_RD, 16'hFFFF, 10'h3FF, 3'd7, 2'd3, 127, 166, 203);
      @(negedge clk);
      req_op   = 2'd2;
      req_addr = 34'h3_FFFF_FFFF;
      acc = -1;
      for (int i = 0; i < 400 && acc < 0; i++) begin
         if (req_ready) acc = cyc;
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_accept", acc, 126);
      wait_until(242);
      check("b2b_ready", req_ready, 1);
      check("b2b_sb_empty", sb.size(), 0);

      // Illegal op=3 runs as read; reset at cycle 60 aborts before PRE.
      do_reset();
      offer(2'd3, 34'h0_0004_0C80);
      sb.push_back('{CMD_ACT, 11, 16'h0001, 10'h000, 3'd1, 2'd3});
      sb.push_back('{CMD_RD, 50, 16'h0001, 10'h000, 3'd1, 2'd3});
      @(negedge clk);
      req_valid = 1'b0;
      wait_until(60);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_ready", req_ready, 1);
      check("abort_valid", cmd_valid, 0);
      check("abort_code", cmd_code, CMD_NOP);
      check("abort_time", cmd_time, 0);
      check("abort_row", cmd_row, 0);
      check("abort_col", cmd_col, 0);
      check("abort_bg", cmd_bg, 0);
      check("abort_ba", cmd_ba, 0);
      check("abort_sb_empty", sb.size(), 0);

      // Fresh write after the aborted request.
      do_reset();
      offer(2'd1, 34'h0_1234_5678);
      push3(CMD_WR, 16'h048D, 10'h05E, 3'd4, 2'd1, 11, 50, 126);
      @(negedge clk);
      req_valid = 1'b0;
      wait_until(165);
      check("post_ready", req_ready, 1);
      check("post_sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
